uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit path for the AXI-lite UART. It is the counterpart of the receive FIFO path. The register block pushes bytes through a write-enable/full interface into a single-entry holding register. A shift-register FSM serialises each byte onto the tx line: start bit, data LSB-first, optional parity, then stop bit(s). The holding register provides double buffering, so consecutive frames run back-to-back with no idle gap.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..8)
CLKS_PER_BIT, 16, clk cycles per bit period (>=2)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
wr_en  input  1  push request from register block
wr_data  input  DATA_WIDTH  byte to transmit
full  output  1  holding register occupied; writes ignored
tx  output  1  serial line, idle high, registered
busy  output  1  FSM not in IDLE
tx_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset values: tx=1, busy=0, full=0, tx_done=0. State=IDLE, holding register invalid, all counters 0.
- Reset mid-frame: tx=1 from the next cycle. The frame in flight and any held byte are discarded. No tx_done pulse is generated.
- Write: wr_en && !full at edge N captures wr_data and sets full=1 after N.
- Write with wr_en && full: silently dropped; no state change.
- IDLE with holding valid: at the next edge, load the shift register, clear holding (full=0), and enter START with tx=0. A write at edge N therefore drives tx low from edge N+1.
- States and transitions:
  - IDLE -> START.
  - START (CLKS_PER_BIT cycles) -> DATA.
  - DATA (DATA_WIDTH bits, LSB first, CLKS_PER_BIT each) -> PARITY if PARITY_EN, else STOP.
  - PARITY (one bit period) -> STOP.
  - STOP (STOP_BITS*CLKS_PER_BIT cycles, tx=1) -> START if holding valid, else IDLE.
- Parity bit: even = XOR of data bits; odd = inverted XOR.
- Frame length: (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, exact.
- Back-to-back: when STOP ends with holding valid, the start bit begins on the very next cycle. The holding register is reloaded on the same edge and full deasserts.
- The holding register accepts a new byte at any time it is empty, including during any frame state.
- tx_done: asserted for one cycle on the edge STOP completes, i.e. coincident with the first cycle of the next IDLE/START.
- busy=1 in every state except IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It clears on every state entry and wraps at CLKS_PER_BIT-1.
- Bit index counter width is $clog2(DATA_WIDTH)+1. No overflow is permitted.

Decomposition:
- uart_pkg (shared with the RX path):
  - FSM state encodings IDLE/START/DATA/PARITY/STOP.
  - Line idle level constant (1).
  - Legal range constants for DATA_WIDTH and STOP_BITS.
- One sub-module, uart_baud_gen: counter with synchronous clear input, emitting a bit_tick output when count==CLKS_PER_BIT-1. The RX sampler will reuse it.

Test Plan:
- Reset: hold rst 3 cycles with wr_en=1, wr_data=0x3C -> tx=1, busy=0, full=0, tx_done=0. Nothing is transmitted after release.
- Single frame, CLKS_PER_BIT=4, 8N1:
  - Stimulus: write 0xA5.
  - tx low 4 cycles, starting the cycle after full rises.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; 40 cycles total.
  - One tx_done pulse; busy falls with it.
- Back-to-back: write 0x55, then 0x0F while the first frame is in DATA.
  - full=1 until the first STOP ends.
  - The second start bit follows the stop bit with zero idle cycles.
  - Two tx_done pulses, exactly 40 cycles apart.
- Overflow: with one frame in flight and holding full, write 0xFF -> write ignored. Only the first two bytes appear on tx; full never glitches.
- Parity/stop options, CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=2:
  - PARITY_EN=1 even, byte 0x07 -> parity bit 1.
  - PARITY_ODD=1, byte 0x07 -> parity bit 0.
  - Stop high 8 cycles; frame exactly 48 cycles.
- Reset mid-DATA: assert rst during bit 3 of 0xC3 -> tx=1, busy=0, full=0 next cycle. No tx_done pulse. The next write of 0x81 transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared types and constants for the UART TX and RX paths.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  // Serial framing FSM states, shared by the transmitter and receiver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Level of the serial line between frames (mark).
  localparam logic c_line_idle = 1'b1;

  // Legal parameter ranges for frame configuration.
  localparam int c_data_width_min = 5;
  localparam int c_data_width_max = 8;
  localparam int c_stop_bits_min  = 1;
  localparam int c_stop_bits_max  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_gen                                                |
// | Description : Bit-period counter with synchronous clear. bit_tick is high  |
// |               on the last clock of each bit period.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign bit_tick = (count_q == c_cnt_last);

  // Restart on clear (state entry) and wrap at the end of each bit period.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clr || bit_tick) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_tx                                                      |
// | Description : UART transmitter. Single-entry holding register in front of  |
// |               a shift-register FSM producing start, data (LSB first),      |
// |               optional parity and stop bits, back-to-back capable.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0] c_last_data = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] c_last_stop = IDX_W'(STOP_BITS - 1);
  localparam logic             c_par_odd   = (PARITY_ODD != 0);
  localparam logic             c_par_en    = (PARITY_EN != 0);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic                  load;
  logic                  baud_clr;
  logic                  bit_tick;

  // The bit-period counter restarts on every state entry and is held in IDLE.
  assign baud_clr = (state_d != state_q) || (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  // Next-state logic: holding-register capture, frame sequencing and line level.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = tx_q;
    tx_done_d    = 1'b0;
    load         = 1'b0;

    // A write is accepted only into an empty holding register; a full one
    // is never consumed in the same cycle it is written, so these don't collide.
    if (wr_en && !hold_valid_q) begin
      hold_d       = wr_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == c_last_data) begin
            bit_idx_d = '0;
            if (c_par_en) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = c_line_idle;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
            tx_d      = shift_d[0];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
          tx_d      = c_line_idle;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          if (bit_idx_q == c_last_stop) begin
            tx_done_d = 1'b1;
            bit_idx_d = '0;
            // A pending byte starts immediately, giving zero idle gap.
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = c_line_idle;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = c_line_idle;
      end
    endcase

    // Move the held byte into the shifter and start the frame with a start bit.
    if (load) begin
      state_d      = ST_START;
      shift_d      = hold_q;
      parity_d     = (^hold_q) ^ c_par_odd;
      hold_valid_d = 1'b0;
      bit_idx_d    = '0;
      tx_d         = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_idx_q    <= '0;
      tx_q         <= c_line_idle;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign full    = hold_valid_q;
  assign tx      = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx                                                   |
// | Description : Self-checking bench for uart_tx: three configurations       |
// |               (8N1, 8E2, 8O2 at 4 clocks/bit) driven with the same         |
// |               directed and random stimulus, compared every cycle against   |
// |               a frame-position reference model.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 4;
  localparam int NCFG = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;

  logic [NCFG-1:0] tx_o, full_o, busy_o, done_o;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_cnt = 0;

  // Reference model configuration per instance.
  int m_pen  [NCFG] = '{0, 1, 1};
  int m_podd [NCFG] = '{0, 0, 1};
  int m_sb   [NCFG] = '{1, 2, 2};

  // Reference model state per instance.
  logic       m_hold_v [NCFG];
  logic [7:0] m_hold   [NCFG];
  logic       m_act    [NCFG];
  logic [7:0] m_byte   [NCFG];
  int         m_cyc    [NCFG];
  logic       m_done   [NCFG];

  int   done_q[$];
  logic rec_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .tx_done(done_o[0]));

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_8e2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .tx_done(done_o[1]));

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_8o2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .tx_done(done_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int k);
    return (1 + 8 + m_pen[k] + m_sb[k]) * CPB;
  endfunction

  // Line level at cycle c of a frame carrying byte b, from the bit layout.
  function automatic logic exp_level(input int k, input logic [7:0] b, input int c);
    int bn;
    bn = c / CPB;
    if (bn == 0) return 1'b0;
    if (bn <= 8) return b[bn-1];
    if (m_pen[k] != 0 && bn == 9) return (^b) ^ (m_podd[k] != 0);
    return 1'b1;
  endfunction

  // Reference model: advances on each rising edge using the inputs in force.
  always @(posedge clk) begin
    cyc_cnt++;
    for (int k = 0; k < NCFG; k++) begin
      if (rst) begin
        m_hold_v[k] = 1'b0;
        m_hold[k]   = '0;
        m_act[k]    = 1'b0;
        m_byte[k]   = '0;
        m_cyc[k]    = 0;
        m_done[k]   = 1'b0;
      end else begin
        logic hv_pre;
        hv_pre    = m_hold_v[k];
        m_done[k] = 1'b0;
        if (m_act[k]) begin
          m_cyc[k]++;
          if (m_cyc[k] == frame_len(k)) begin
            m_act[k]  = 1'b0;
            m_done[k] = 1'b1;
          end
        end
        if (!m_act[k] && hv_pre) begin
          m_act[k]    = 1'b1;
          m_byte[k]   = m_hold[k];
          m_cyc[k]    = 0;
          m_hold_v[k] = 1'b0;
        end
        if (wr_en && !hv_pre) begin
          m_hold[k]   = wr_data;
          m_hold_v[k] = 1'b1;
        end
      end
    end
  end

  // Compare every instance against the model on the falling edge.
  always @(negedge clk) begin
    if (cyc_cnt > 0) begin
      for (int k = 0; k < NCFG; k++) begin
        logic [3:0] got, exp;
        logic       lvl;
        lvl = m_act[k] ? exp_level(k, m_byte[k], m_cyc[k]) : 1'b1;
        got = {tx_o[k], busy_o[k], full_o[k], done_o[k]};
        exp = {lvl, m_act[k], m_hold_v[k], m_done[k]};
        check($sformatf("cfg%0d_tx_busy_full_done", k), 32'(got), 32'(exp));
      end
      if (rec_en && done_o[0]) done_q.push_back(cyc_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    step(3);
    rst   = 1'b0;
    wr_en = 1'b0;
    step(10);

    // Single frame.
    write_byte(8'hA5);
    step(55);

    // Back-to-back with an overflowing third write.
    done_q.delete();
    rec_en = 1'b1;
    write_byte(8'h55);
    step(12);
    write_byte(8'h0F);
    step(5);
    write_byte(8'hFF);
    step(90);
    rec_en = 1'b0;
    check("b2b_done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() >= 2) check("b2b_done_gap", 32'(done_q[1] - done_q[0]), 32'd40);
    step(20);

    // Parity / two stop bits.
    write_byte(8'h07);
    step(60);

    // Reset during data bit 3.
    write_byte(8'hC3);
    step(18);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    write_byte(8'h81);
    step(60);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_data = 8'($urandom);
      step(1);
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    step(120);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
